tmds_channel_decoder: RTL and testbench
=======================================

Name: tmds_channel_decoder

Overview:
Receive-side counterpart of the HDMI/DVI transmit path. Takes one TMDS channel's 10-bit parallel symbols from an external deserializer and finds word alignment by issuing bitslip pulses until control tokens appear. Once aligned, it decodes each symbol back to 8-bit pixel data or the C0/C1 control bits, with a DE flag. Used for loopback verification of the video output and for a future capture input; instantiated once per channel (B, G, R).

Parameters:
CTL_RUN, 8, consecutive control tokens required to declare lock (range 2..255)
SEARCH_CYCLES, 2048, cycles in SEARCH without lock before a bitslip; also the maximum control-token gap tolerated in LOCKED (must exceed one video line)
SLIP_WAIT, 4, settle cycles after a BITSLIP pulse before searching resumes (range 1..15)

Ports:
CLK_PIXEL  in  1  pixel clock; the only clock in the block; SYM_IN is sampled on every rising edge
RESET  in  1  synchronous, active-high reset
SYM_IN  in  10  TMDS symbol from the deserializer; bit 0 is the first bit on the wire
BITSLIP  out  1  one-cycle pulse asking the deserializer to shift alignment by one bit
LOCKED  out  1  high while the channel is aligned
DE  out  1  high for a video-data symbol; low for a control token
C0  out  1  control bit 0, valid when DE=0
C1  out  1  control bit 1, valid when DE=0
DATA  out  8  decoded pixel byte, valid when DE=1

Behaviour:
- Reset (RESET high at a clock edge): FSM=SEARCH; all counters 0; BITSLIP=0, LOCKED=0, DE=0, C0=0, C1=0, DATA=0. RESET has priority over every other event, including mid-slip or mid-settle.
- Control tokens and their outputs:
  - 0x354 -> C1C0=00
  - 0x0AB -> C1C0=01
  - 0x154 -> C1C0=10
  - 0x2AB -> C1C0=11
  - Any other value is a data symbol.
- Data decode:
  - d = SYM_IN[9] ? ~SYM_IN[7:0] : SYM_IN[7:0]
  - q[0] = d[0]
  - for i=1..7: q[i] = SYM_IN[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Pipeline:
  - Stage 1 registers SYM_IN and the token match.
  - Stage 2 registers DE/C0/C1/DATA.
  - Latency is 2 cycles from SYM_IN to the outputs.
  - When LOCKED (as registered at stage 2) is low, stage 2 forces DE=0, C0=0, C1=0, DATA=0.
- FSM, evaluated on the stage-1 token flag:
  - SEARCH:
    - run counter +1 on each control token; cleared to 0 on each data symbol.
    - Timer +1 every cycle.
    - run reaches CTL_RUN -> LOCKED. LOCKED goes high the next cycle.
    - Otherwise, timer reaches SEARCH_CYCLES-1 -> SLIP.
    - If both happen in the same cycle, lock wins.
  - SLIP: BITSLIP=1 for exactly one cycle, then SETTLE. Counters are cleared.
  - SETTLE: wait SLIP_WAIT cycles with BITSLIP=0 and symbols ignored, then SEARCH.
  - LOCKED:
    - Gap counter cleared on each control token; +1 on each data symbol.
    - Gap reaches SEARCH_CYCLES -> SEARCH. LOCKED drops the next cycle; run counter and timer are cleared.
- Slipping is unbounded: with no valid tokens, BITSLIP pulses every SEARCH_CYCLES+1+SLIP_WAIT cycles and wraps past 10 positions indefinitely (the deserializer owns the wrap).
- Counter widths: sized for the parameter maxima; saturating, never wrapping.

Optional Feature:
TMDS_STATS_EN.
- Defined: adds output SLIP_CNT [7:0], counting BITSLIP pulses, and output LOSS_CNT [7:0], counting LOCKED->SEARCH transitions. Both saturate at 255 and are cleared only by RESET.
- Undefined: neither port exists and no counter logic is built. Core behaviour is identical in both builds.

Test Plan:
- Aligned stream, 16x 0x354 then data 0x1F0 -> LOCKED high after the 8th token (+1 cycle). The 0x354 tokens give DE=0, C1C0=00. The 0x1F0 symbol appears 2 cycles after input with DE=1, DATA=0x10.
- Aligned tokens 0x0AB, 0x154, 0x2AB while locked -> C1C0 = 01, 10, 11 with DE=0 each, 2-cycle latency.
- Stream rotated by 3 bits, bench model rotates by one bit per BITSLIP -> exactly 3 BITSLIP pulses, each 2048+1+4 cycles apart, then LOCKED. With TMDS_STATS_EN: SLIP_CNT=3.
- Locked, then 2048 consecutive data symbols -> LOCKED falls and DE is forced 0. With TMDS_STATS_EN: LOSS_CNT=1. Tokens resume -> relock after 8 tokens.
- RESET asserted for one cycle in SETTLE and again in LOCKED -> all outputs 0 on the next cycle, FSM back in SEARCH, no stray BITSLIP pulse.
- Run of 7 tokens, then one data word, then 7 tokens -> no lock (run counter cleared by the data word).

Source files
------------

// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: symbol input and decoded outputs for one TMDS channel
//   sym      10-bit symbol from the deserializer; bit 0 is the first bit on the wire
//   bitslip  one-cycle request to the deserializer to shift alignment by one bit
//   locked   channel word-aligned
//   de       video-data symbol (0 for a control token)
//   c0, c1   control bits, valid when de=0
//   data     decoded pixel byte, valid when de=1
//   slip_cnt, loss_cnt  saturating statistics, present only with TMDS_STATS_EN
interface tmds_channel_decoder_if;
    logic [9:0] sym;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] data;
`ifdef TMDS_STATS_EN
    logic [7:0] slip_cnt;
    logic [7:0] loss_cnt;
    modport master(output sym, input bitslip, locked, de, c0, c1, data, slip_cnt, loss_cnt);
    modport slave(input sym, output bitslip, locked, de, c0, c1, data, slip_cnt, loss_cnt);
`else
    modport master(output sym, input bitslip, locked, de, c0, c1, data);
    modport slave(input sym, output bitslip, locked, de, c0, c1, data);
`endif
endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS word alignment by bitslip search and symbol decode for one channel
//   clk  pixel clock, the only clock
//   rst  synchronous active-high reset
//   bus  slave side of tmds_channel_decoder_if (sym in; bitslip, locked, de, c0, c1, data out)
//   Define TMDS_STATS_EN to add the slip_cnt / loss_cnt statistics counters.
module tmds_channel_decoder #(
    parameter int CTL_RUN       = 8,
    parameter int SEARCH_CYCLES = 2048,
    parameter int SLIP_WAIT     = 4
) (
    input logic clk,
    input logic rst,
    tmds_channel_decoder_if.slave bus
);
    localparam int TW = $clog2(SEARCH_CYCLES + 1);
    localparam logic [7:0] RUN_LAST = 8'(CTL_RUN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(SEARCH_CYCLES - 1);
    localparam logic [TW-1:0] W_LAST = TW'(SLIP_WAIT - 1);
    typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCK} state_t;
    state_t state;
    logic [9:0] sym_q;
    logic tok_q;
    logic [1:0] ctl_q;
    logic [7:0] run;
    // one counter serves as search timer, settle counter and locked token-gap counter
    logic [TW-1:0] timer;
    logic tok;
    logic [1:0] ctl;
    logic [7:0] d;
    logic [7:0] q;
    logic lose;
    assign tok = bus.sym == 10'h354 || bus.sym == 10'h0AB || bus.sym == 10'h154 || bus.sym == 10'h2AB;
    assign ctl = {bus.sym == 10'h154 || bus.sym == 10'h2AB, bus.sym == 10'h0AB || bus.sym == 10'h2AB};
    assign d = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    assign q = {sym_q[8] ? d[7:1] ^ d[6:0] : ~(d[7:1] ^ d[6:0]), d[0]};
    assign lose = state == LOCK && !tok_q && timer == T_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_q    <= '0;
            tok_q    <= 1'b0;
            ctl_q    <= '0;
            bus.de   <= 1'b0;
            bus.c0   <= 1'b0;
            bus.c1   <= 1'b0;
            bus.data <= '0;
        end else begin
            sym_q    <= bus.sym;
            tok_q    <= tok;
            ctl_q    <= ctl;
            bus.de   <= bus.locked && !tok_q;
            bus.c0   <= bus.locked && tok_q && ctl_q[0];
            bus.c1   <= bus.locked && tok_q && ctl_q[1];
            bus.data <= bus.locked && !tok_q ? q : 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            run         <= '0;
            timer       <= '0;
            bus.bitslip <= 1'b0;
            bus.locked  <= 1'b0;
        end else begin
            bus.bitslip <= 1'b0;
            case (state)
                SEARCH: begin
                    if (tok_q && run == RUN_LAST) begin
                        state      <= LOCK;
                        bus.locked <= 1'b1;
                        run        <= '0;
                        timer      <= '0;
                    end else if (timer == T_LAST) begin
                        state       <= SLIP;
                        bus.bitslip <= 1'b1;
                        run         <= '0;
                        timer       <= '0;
                    end else begin
                        run   <= tok_q ? run + 8'd1 : 8'd0;
                        timer <= timer + TW'(1);
                    end
                end
                SLIP: state <= SETTLE;
                SETTLE: begin
                    state <= timer == W_LAST ? SEARCH : SETTLE;
                    timer <= timer == W_LAST ? '0 : timer + TW'(1);
                end
                LOCK: begin
                    if (lose) begin
                        state      <= SEARCH;
                        bus.locked <= 1'b0;
                        run        <= '0;
                        timer      <= '0;
                    end else begin
                        timer <= tok_q ? '0 : timer + TW'(1);
                    end
                end
            endcase
        end
    end
`ifdef TMDS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.slip_cnt <= '0;
            bus.loss_cnt <= '0;
        end else begin
            if (bus.bitslip && bus.slip_cnt != 8'hFF) bus.slip_cnt <= bus.slip_cnt + 8'd1;
            if (lose && bus.loss_cnt != 8'hFF) bus.loss_cnt <= bus.loss_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed-vector bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0;
    int nerr = 0;
    int n;
    int slips;
    int last;
    tmds_channel_decoder_if bus();
    tmds_channel_decoder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {
        logic [9:0] s;
        logic       de;
        logic [1:0] c;
        logic [7:0] d;
    } vec_t;
    vec_t vt [11] = '{
        '{10'h354, 1'b0, 2'd0, 8'h00},
        '{10'h1F0, 1'b1, 2'd0, 8'h10},
        '{10'h0AB, 1'b0, 2'd1, 8'h00},
        '{10'h154, 1'b0, 2'd2, 8'h00},
        '{10'h2AB, 1'b0, 2'd3, 8'h00},
        '{10'h000, 1'b1, 2'd0, 8'hFE},
        '{10'h2FF, 1'b1, 2'd0, 8'hFE},
        '{10'h1FF, 1'b1, 2'd0, 8'h01},
        '{10'h155, 1'b1, 2'd0, 8'hFF},
        '{10'h100, 1'b1, 2'd0, 8'h00},
        '{10'h354, 1'b0, 2'd0, 8'h00}
    };
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic [9:0] s);
        bus.sym = s;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {21'd0, bus.bitslip, bus.locked, bus.de, bus.c1, bus.c0, bus.data}, 32'd0);
    endtask
    function automatic logic [9:0] rotl(input logic [9:0] x, input int k);
        logic [19:0] t;
        t = {x, x} << k;
        return t[19:10];
    endfunction
    initial begin
        bus.sym = 10'h0;
        cyc(10'h0);
        cyc(10'h0);
        rst = 1'b0;
        chk("rst_locked", bus.locked, 0);
        chk("rst_bitslip", bus.bitslip, 0);
        chk_zero("rst");
        // 7 tokens, one data word, 7 tokens: run counter restarts, no lock
        for (int i = 0; i < 7; i++) cyc(10'h354);
        cyc(10'h1F0);
        for (int i = 0; i < 7; i++) cyc(10'h354);
        cyc(10'h1F0);
        cyc(10'h1F0);
        chk("no_lock_7_1_7", bus.locked, 0);
        // 16 tokens: lock visible one cycle after the 8th token is registered
        for (int i = 1; i <= 16; i++) begin
            cyc(10'h354);
            if (i == 8) chk("lock_before", bus.locked, 0);
            if (i == 9) chk("lock_after", bus.locked, 1);
        end
        chk("tok_354", {bus.de, bus.c1, bus.c0}, 3'b000);
        // decoded outputs lag the input by two edges, i.e. one call of cyc
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].s);
            if (i > 0) chk($sformatf("vec%0d", i - 1), {bus.de, bus.c1, bus.c0, bus.data}, {vt[i-1].de, vt[i-1].c, vt[i-1].d});
        end
        cyc(10'h354);
        chk("vec10", {bus.de, bus.c1, bus.c0, bus.data}, {vt[10].de, vt[10].c, vt[10].d});
        // 2048 consecutive data symbols drop lock
        for (int i = 1; i <= 2050; i++) begin
            cyc(10'h1F0);
            if (i == 2048) chk("loss_before", bus.locked, 1);
            if (i == 2049) chk("loss_after", bus.locked, 0);
            if (i == 2050) chk("loss_de_forced", {bus.de, bus.data}, 9'd0);
        end
`ifdef TMDS_STATS_EN
        chk("loss_cnt", bus.loss_cnt, 1);
`endif
        for (int i = 1; i <= 9; i++) begin
            cyc(10'h354);
            if (i == 8) chk("relock_before", bus.locked, 0);
            if (i == 9) chk("relock_after", bus.locked, 1);
        end
        // reset while locked
        rst = 1'b1;
        cyc(10'h1F0);
        rst = 1'b0;
        chk_zero("rst_locked");
        for (n = 1; n < 3000; n++) begin
            cyc(10'h1F0);
            if (bus.bitslip) break;
        end
        chk("slip_after_rst_locked", n, 2048);
        // reset during settle: no stray pulse and a full search period follows
        cyc(10'h1F0);
        rst = 1'b1;
        cyc(10'h1F0);
        rst = 1'b0;
        chk_zero("rst_settle");
        for (n = 1; n < 3000; n++) begin
            cyc(10'h1F0);
            if (bus.bitslip) break;
        end
        chk("slip_after_rst_settle", n, 2048);
        // stream rotated by 3 bits; each bitslip moves the model one bit closer
        rst = 1'b1;
        cyc(10'h0);
        rst = 1'b0;
        slips = 0;
        last = 0;
        for (int k = 1; k <= 10000 && !bus.locked; k++) begin
            cyc(rotl(10'h354, (7 + slips) % 10));
            if (bus.bitslip) begin
                if (slips > 0) chk($sformatf("slip_gap%0d", slips), k - last, 2053);
                last = k;
                slips++;
            end
        end
        chk("rot_locked", bus.locked, 1);
        chk("rot_slips", slips, 3);
        for (int k = 0; k < 50; k++) begin
            cyc(10'h354);
            if (bus.bitslip) slips++;
        end
        chk("rot_slips_hold", slips, 3);
        chk("rot_locked_hold", bus.locked, 1);
`ifdef TMDS_STATS_EN
        chk("slip_cnt", bus.slip_cnt, 3);
        chk("loss_cnt_rot", bus.loss_cnt, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
